// File: rtl/row_acc_18.sv
// Row accumulator for the 18-bit signed product stream: per flux, read one block size,
// then emit one 25-bit row sum for every max+1 products, with lowest-index flux arbitration.
module row_acc_18 #(
    parameter int FLUX                = 2,
    parameter int DATA_WIDTH_EXT_SIZE = 7,
    parameter int DATA_WIDTH_PROD     = 18,
    parameter int DATA_WIDTH_SUM      = 25,
    localparam int TAG_WIDTH          = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [FLUX-1:0]                          read_port_prod_empty_i,
    output logic [FLUX-1:0]                          read_port_prod_read_o,
    input  logic [DATA_WIDTH_PROD+TAG_WIDTH-1:0]     read_port_prod_dout_i,
    input  logic [FLUX-1:0]                          read_port_ext_size_empty_i,
    output logic [FLUX-1:0]                          read_port_ext_size_read_o,
    input  logic [DATA_WIDTH_EXT_SIZE+TAG_WIDTH-1:0] read_port_ext_size_dout_i,
    input  logic [FLUX-1:0]                          write_port_sum_full_i,
    output logic [FLUX-1:0]                          write_port_sum_write_o,
    output logic [DATA_WIDTH_SUM+TAG_WIDTH-1:0]      write_port_sum_din_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH_EXT_SIZE-1:0] CNT_ONE = DATA_WIDTH_EXT_SIZE'(1);

    state_t                          state_q [FLUX];
    state_t                          state_d [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0]  max_q   [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0]  max_d   [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0]  cnt_h_q [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0]  cnt_h_d [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0]  cnt_v_q [FLUX];
    logic [DATA_WIDTH_EXT_SIZE-1:0]  cnt_v_d [FLUX];
    logic signed [DATA_WIDTH_SUM-1:0] acc_q  [FLUX];
    logic signed [DATA_WIDTH_SUM-1:0] acc_d  [FLUX];

    logic [FLUX-1:0]                  elig;
    logic                             act;
    logic [TAG_WIDTH-1:0]             tag;
    logic [DATA_WIDTH_PROD-1:0]       prod_pl;
    logic [DATA_WIDTH_EXT_SIZE-1:0]   ext_pl;
    logic signed [DATA_WIDTH_SUM-1:0] prod_sext;
    logic signed [DATA_WIDTH_SUM-1:0] sum;

    // Incoming tag fields are not needed: the FIFO side already presents the selected flux.
    logic unused_dout_tags;
    assign unused_dout_tags = ^{read_port_prod_dout_i[DATA_WIDTH_PROD+TAG_WIDTH-1:DATA_WIDTH_PROD],
                                read_port_ext_size_dout_i[DATA_WIDTH_EXT_SIZE+TAG_WIDTH-1:DATA_WIDTH_EXT_SIZE]};

    assign prod_pl   = read_port_prod_dout_i[DATA_WIDTH_PROD-1:0];
    assign ext_pl    = read_port_ext_size_dout_i[DATA_WIDTH_EXT_SIZE-1:0];
    assign prod_sext = {{(DATA_WIDTH_SUM-DATA_WIDTH_PROD){prod_pl[DATA_WIDTH_PROD-1]}}, prod_pl};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                state_q[i] <= IDLE;
                max_q[i]   <= '0;
                cnt_h_q[i] <= '0;
                cnt_v_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        elig = '0;
        act  = 1'b0;
        tag  = '0;
        // Descending scan so the lowest eligible index is the last one written.
        for (int i = FLUX - 1; i >= 0; i--) begin
            elig[i] = ((state_q[i] == IDLE) && !read_port_ext_size_empty_i[i]) ||
                      ((state_q[i] == WORK) && !read_port_prod_empty_i[i] &&
                       ((cnt_h_q[i] < max_q[i]) || !write_port_sum_full_i[i]));
            if (elig[i]) begin
                act = 1'b1;
                tag = TAG_WIDTH'(i);
            end
        end
    end

    assign sum = acc_q[tag] + prod_sext;

    always_comb begin
        state_d                   = state_q;
        max_d                     = max_q;
        cnt_h_d                   = cnt_h_q;
        cnt_v_d                   = cnt_v_q;
        acc_d                     = acc_q;
        read_port_prod_read_o     = '0;
        read_port_ext_size_read_o = '0;
        write_port_sum_write_o    = '0;
        write_port_sum_din_o      = '0;
        if (act) begin
            if (state_q[tag] == IDLE) begin
                read_port_ext_size_read_o[tag] = 1'b1;
                max_d[tag]   = ext_pl;
                cnt_h_d[tag] = '0;
                cnt_v_d[tag] = '0;
                acc_d[tag]   = '0;
                state_d[tag] = WORK;
            end else if (cnt_h_q[tag] < max_q[tag]) begin
                read_port_prod_read_o[tag] = 1'b1;
                acc_d[tag]   = sum;
                cnt_h_d[tag] = cnt_h_q[tag] + CNT_ONE;
            end else begin
                read_port_prod_read_o[tag]  = 1'b1;
                write_port_sum_write_o[tag] = 1'b1;
                write_port_sum_din_o        = {tag, sum};
                acc_d[tag]   = '0;
                cnt_h_d[tag] = '0;
                if (cnt_v_q[tag] < max_q[tag]) begin
                    cnt_v_d[tag] = cnt_v_q[tag] + CNT_ONE;
                end else begin
                    cnt_v_d[tag] = '0;
                    state_d[tag] = IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_row_acc_18.sv
// Directed bench for row_acc_18: queue-modelled FIFOs per flux, captured row sums
// compared against hand-computed totals.
module tb_row_acc_18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  p_empty, p_read, e_empty, e_read, s_full, s_write;
    logic [18:0] p_dout;
    logic [7:0]  e_dout;
    logic [25:0] s_din;
    logic [17:0] hp0, hp1;
    logic [6:0]  he0, he1;

    logic [17:0] pq0[$], pq1[$];
    logic [6:0]  eq0[$], eq1[$];
    logic [25:0] got0[$], got1[$];
    logic [1:0]  l_p_read, l_e_read, l_write;
    int checks = 0, failures = 0, bad_din = 0, bad_onehot = 0;

    always #5 clk = ~clk;

    // The FIFO bank presents the head of whichever flux is being read.
    assign p_dout = p_read[1] ? {1'b1, hp1} : {1'b0, hp0};
    assign e_dout = e_read[1] ? {1'b1, he1} : {1'b0, he0};

    row_acc_18 dut (
        .clk                        (clk),
        .rst                        (rst),
        .read_port_prod_empty_i     (p_empty),
        .read_port_prod_read_o      (p_read),
        .read_port_prod_dout_i      (p_dout),
        .read_port_ext_size_empty_i (e_empty),
        .read_port_ext_size_read_o  (e_read),
        .read_port_ext_size_dout_i  (e_dout),
        .write_port_sum_full_i      (s_full),
        .write_port_sum_write_o     (s_write),
        .write_port_sum_din_o       (s_din)
    );

    task automatic upd();
        p_empty = {pq1.size() == 0, pq0.size() == 0};
        e_empty = {eq1.size() == 0, eq0.size() == 0};
        hp0 = (pq0.size() > 0) ? pq0[0] : '0;
        hp1 = (pq1.size() > 0) ? pq1[0] : '0;
        he0 = (eq0.size() > 0) ? eq0[0] : '0;
        he1 = (eq1.size() > 0) ? eq1[0] : '0;
    endtask

    task automatic step();
        @(negedge clk);
        l_p_read = p_read;
        l_e_read = e_read;
        l_write  = s_write;
        if (s_write[0]) got0.push_back(s_din);
        if (s_write[1]) got1.push_back(s_din);
        if (s_write == 2'b00 && s_din != '0) bad_din++;
        if ($countones({p_read, e_read}) > 1 || (s_write != 2'b00 && s_write != p_read)) bad_onehot++;
        @(posedge clk);
        #1;
        if (l_p_read[0] && pq0.size() > 0) void'(pq0.pop_front());
        if (l_p_read[1] && pq1.size() > 0) void'(pq1.pop_front());
        if (l_e_read[0] && eq0.size() > 0) void'(eq0.pop_front());
        if (l_e_read[1] && eq1.size() > 0) void'(eq1.pop_front());
        upd();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_full = 2'b00;
        upd();
        run(2);
        checks++;
        if ({p_read, e_read, s_write} !== 6'b0 || s_din !== 26'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h exp=0/0", {p_read, e_read, s_write}, s_din);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        got0.delete(); got1.delete();
        eq0.push_back(7'd1);
        pq0.push_back(18'd3); pq0.push_back(18'h3FFFB); pq0.push_back(18'd7); pq0.push_back(18'd100);
        upd();
        step();
        checks++;
        if (l_e_read !== 2'b01) begin
            failures++; $display("FAIL basic_ext_read got=%b exp=01", l_e_read);
        end
        run(4);
        checks++;
        if (got0.size() != 2 || got0[0] !== {1'b0, 25'h1FFFFFE} || got0[1] !== {1'b0, 25'd107}) begin
            failures++;
            $display("FAIL basic_sums got n=%0d %h %h exp n=2 %h %h", got0.size(), got0[0], got0[1],
                     {1'b0, 25'h1FFFFFE}, {1'b0, 25'd107});
        end
        eq0.push_back(7'd0);
        pq0.push_back(18'd1);
        upd();
        step();
        checks++;
        if (l_e_read !== 2'b01) begin
            failures++; $display("FAIL basic_back_to_idle got=%b exp=01", l_e_read);
        end
        step();
        checks++;
        if (got0.size() != 3 || got0[2] !== {1'b0, 25'd1}) begin
            failures++; $display("FAIL basic_next_block got n=%0d %h exp n=3 %h", got0.size(), got0[2], {1'b0, 25'd1});
        end
    endtask

    task automatic test_max0();
        got0.delete(); got1.delete();
        eq0.push_back(7'd0); eq0.push_back(7'd0);
        pq0.push_back(18'h20000); pq0.push_back(18'd5);
        upd();
        step();
        checks++;
        if (l_e_read !== 2'b01 || l_p_read !== 2'b00) begin
            failures++; $display("FAIL max0_c1 got e=%b p=%b exp e=01 p=00", l_e_read, l_p_read);
        end
        step();
        checks++;
        if (l_p_read !== 2'b01 || l_write !== 2'b01) begin
            failures++; $display("FAIL max0_c2 got p=%b w=%b exp p=01 w=01", l_p_read, l_write);
        end
        step();
        checks++;
        if (l_e_read !== 2'b01) begin
            failures++; $display("FAIL max0_next_ext got=%b exp=01", l_e_read);
        end
        step();
        checks++;
        if (got0.size() != 2 || got0[0] !== {1'b0, 25'h1FE0000} || got0[1] !== {1'b0, 25'd5}) begin
            failures++;
            $display("FAIL max0_sums got n=%0d %h %h exp n=2 %h %h", got0.size(), got0[0], got0[1],
                     {1'b0, 25'h1FE0000}, {1'b0, 25'd5});
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        got0.delete(); got1.delete();
        eq0.push_back(7'd127);
        for (int i = 0; i < 16384; i++) pq0.push_back(18'h20000);
        upd();
        run(16400);
        checks++;
        if (got0.size() != 128) begin
            failures++; $display("FAIL ovf_count got=%0d exp=128", got0.size());
        end
        for (int i = 0; i < got0.size(); i++) if (got0[i] !== {1'b0, 25'h1000000}) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL ovf_values got %0d wrong sums exp all %h", bad, {1'b0, 25'h1000000});
        end
        eq0.push_back(7'd0);
        pq0.push_back(18'd3);
        upd();
        run(3);
        checks++;
        if (got0.size() != 129 || got0[128] !== {1'b0, 25'd3}) begin
            failures++; $display("FAIL ovf_reidle got n=%0d %h exp n=129 %h", got0.size(), got0[128], {1'b0, 25'd3});
        end
    endtask

    task automatic test_full_stall();
        got0.delete(); got1.delete();
        s_full = 2'b01;
        eq0.push_back(7'd1);
        pq0.push_back(18'd10); pq0.push_back(18'd20); pq0.push_back(18'd30); pq0.push_back(18'd40);
        eq1.push_back(7'd0);
        pq1.push_back(18'd9);
        upd();
        run(2);
        step();
        checks++;
        if (l_p_read !== 2'b00 || l_e_read !== 2'b10) begin
            failures++; $display("FAIL stall_c3 got p=%b e=%b exp p=00 e=10", l_p_read, l_e_read);
        end
        step();
        checks++;
        if (l_p_read !== 2'b10 || l_write !== 2'b10) begin
            failures++; $display("FAIL stall_flux1 got p=%b w=%b exp p=10 w=10", l_p_read, l_write);
        end
        step();
        checks++;
        if (got1.size() != 1 || got1[0] !== {1'b1, 25'd9} || got0.size() != 0 || pq0.size() != 3) begin
            failures++;
            $display("FAIL stall_hold got n1=%0d %h n0=%0d q0=%0d exp n1=1 %h n0=0 q0=3",
                     got1.size(), got1[0], got0.size(), pq0.size(), {1'b1, 25'd9});
        end
        s_full = 2'b00;
        run(4);
        checks++;
        if (got0.size() != 2 || got0[0] !== {1'b0, 25'd30} || got0[1] !== {1'b0, 25'd70}) begin
            failures++;
            $display("FAIL stall_release got n=%0d %h %h exp n=2 %h %h", got0.size(), got0[0], got0[1],
                     {1'b0, 25'd30}, {1'b0, 25'd70});
        end
    endtask

    task automatic test_interleave();
        logic [17:0] a0[4] = '{18'd1, 18'd2, 18'd3, 18'd4};
        logic [17:0] a1[9] = '{18'd10, 18'h3FFEC, 18'd30, 18'd1, 18'd1, 18'd1, 18'h3FF9C, 18'd50, 18'd25};
        got0.delete(); got1.delete();
        eq0.push_back(7'd1);
        eq1.push_back(7'd2);
        upd();
        for (int k = 0; k < 9; k++) begin
            if (k < 4) pq0.push_back(a0[k]);
            upd();
            step();
            pq1.push_back(a1[k]);
            upd();
            step();
        end
        run(10);
        checks++;
        if (got0.size() != 2 || got0[0] !== {1'b0, 25'd3} || got0[1] !== {1'b0, 25'd7}) begin
            failures++; $display("FAIL ilv_flux0 got n=%0d %h %h exp n=2 %h %h", got0.size(), got0[0], got0[1],
                                 {1'b0, 25'd3}, {1'b0, 25'd7});
        end
        checks++;
        if (got1.size() != 3 || got1[0] !== {1'b1, 25'd20} || got1[1] !== {1'b1, 25'd3} ||
            got1[2] !== {1'b1, 25'h1FFFFE7}) begin
            failures++; $display("FAIL ilv_flux1 got n=%0d %h %h %h exp n=3 %h %h %h", got1.size(),
                                 got1[0], got1[1], got1[2], {1'b1, 25'd20}, {1'b1, 25'd3}, {1'b1, 25'h1FFFFE7});
        end
    endtask

    task automatic test_reset_mid();
        got0.delete(); got1.delete();
        eq0.push_back(7'd1);
        pq0.push_back(18'd5); pq0.push_back(18'd6);
        upd();
        run(4);
        checks++;
        if (got0.size() != 1 || got0[0] !== {1'b0, 25'd11}) begin
            failures++; $display("FAIL rstmid_pre got n=%0d %h exp n=1 %h", got0.size(), got0[0], {1'b0, 25'd11});
        end
        got0.delete();
        rst = 1'b1;
        upd();
        run(2);
        rst = 1'b0;
        eq0.push_back(7'd1);
        for (int i = 0; i < 4; i++) pq0.push_back(18'd1);
        upd();
        step();
        checks++;
        if (l_e_read !== 2'b01 || l_p_read !== 2'b00) begin
            failures++; $display("FAIL rstmid_idle got e=%b p=%b exp e=01 p=00", l_e_read, l_p_read);
        end
        run(6);
        checks++;
        if (got0.size() != 2 || got0[0] !== {1'b0, 25'd2} || got0[1] !== {1'b0, 25'd2}) begin
            failures++; $display("FAIL rstmid_sums got n=%0d %h %h exp n=2 %h %h", got0.size(), got0[0], got0[1],
                                 {1'b0, 25'd2}, {1'b0, 25'd2});
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (bad_din != 0) begin
            failures++; $display("FAIL din_idle_zero got=%0d cycles exp=0", bad_din);
        end
        checks++;
        if (bad_onehot != 0) begin
            failures++; $display("FAIL single_action got=%0d cycles exp=0", bad_onehot);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max0();
        test_overflow();
        test_full_stall();
        test_interleave();
        test_reset_mid();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
